// File: rtl/stat_bist_driver.sv
// rtl/stat_bist_driver.sv - LFSR pattern source and MISR response sink for combinational benchmarks
// Optional expected-signature compare enabled by defining STAT_BIST_EXPECT_EN.
module stat_bist_driver #(
    parameter int              IN_W      = 31,
    parameter int              OUT_W     = 17,
    parameter int              CNT_W     = 16,
    parameter logic [IN_W-1:0] LFSR_SEED = 31'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic             seed_load,
    input  logic [IN_W-1:0]  seed,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
`ifdef STAT_BIST_EXPECT_EN
    input  logic [OUT_W-1:0] expected_sig,
    output logic             pass,
`endif
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] pattern_idx
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  lfsr_q, lfsr_d;
    logic [IN_W-1:0]  seed_q, seed_d;
    logic [OUT_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] n_q, n_d;

    logic             idle_or_done;
    logic             start_ok;
    logic             seed_ok;
    logic             last_pattern;
    logic [IN_W-1:0]  seed_fixed;

    always_comb begin
        idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
        start_ok     = start && idle_or_done;
        seed_ok      = seed_load && idle_or_done;
        last_pattern = ((idx_q + {{(CNT_W-1){1'b0}}, 1'b1}) == n_q);
        // An all-zero seed would lock the LFSR, so it is stored as 1.
        seed_fixed   = (seed == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : seed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (num_patterns != '0) ? S_APPLY : S_DONE;
                end
            end
            S_APPLY:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = last_pattern ? S_DONE : S_APPLY;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_APPLY) || (state_q == S_CAPTURE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        seed_d = seed_ok ? seed_fixed : seed_q;
        lfsr_d = lfsr_q;
        sig_d  = sig_q;
        idx_d  = idx_q;
        n_d    = n_q;
        if (start_ok) begin
            // seed_d already reflects a same-cycle seed_load.
            lfsr_d = seed_d;
            sig_d  = '0;
            idx_d  = '0;
            n_d    = num_patterns;
        end else if (state_q == S_CAPTURE) begin
            sig_d  = {sig_q[OUT_W-2:0], sig_q[OUT_W-1] ^ sig_q[OUT_W-4]} ^ dut_out;
            lfsr_d = {lfsr_q[IN_W-2:0], lfsr_q[IN_W-1] ^ lfsr_q[IN_W-4]};
            idx_d  = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            seed_q <= LFSR_SEED;
            sig_q  <= '0;
            idx_q  <= '0;
            n_q    <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            seed_q <= seed_d;
            sig_q  <= sig_d;
            idx_q  <= idx_d;
            n_q    <= n_d;
        end
    end

    assign dut_in      = lfsr_q;
    assign signature   = sig_q;
    assign pattern_idx = idx_q;

`ifdef STAT_BIST_EXPECT_EN
    logic pass_q, pass_d;

    always_comb begin
        pass_d = pass_q;
        if (start_ok) begin
            pass_d = 1'b0;
        end
        // Entry to DONE, including a zero-length run started from DONE.
        if ((state_d == S_DONE) && ((state_q != S_DONE) || start_ok)) begin
            pass_d = (sig_d == expected_sig);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end

    assign pass = pass_q;
`endif

endmodule
